// File: rtl/cond_code_unit.sv
// Processor status (flag) register and branch/set condition evaluator.
// Latency: flags register on the clk edge after capture; condMet is combinational from effective flags.
// No backpressure: the controller strobes captures and writes, and this block always accepts them.
module cond_code_unit #(
  parameter int WIDTH  = 16,
  parameter bit BYPASS = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             codesComputed,
  input  logic [4:0]       aluFlags,
  input  logic             psrWrEn,
  input  logic [WIDTH-1:0] psrWrData,
  input  logic [3:0]       condField,
  output logic [WIDTH-1:0] conCodesOut,
  output logic             carryIn,
  output logic [WIDTH-1:0] sCondValue,
  output logic             flagsValid
);

  // Flag bit positions within the 5-bit {N,Z,F,L,C} vector.
  localparam int N_BIT = 4;
  localparam int Z_BIT = 3;
  localparam int F_BIT = 2;
  localparam int L_BIT = 1;
  localparam int C_BIT = 0;

  logic [4:0] flags_q, flags_d;
  logic       valid_q, valid_d;
  logic [4:0] eff_flags;
  logic       cond_met;

  // Only the low five PSR bits carry state; upper bits are intentionally dropped.
  logic unused_psr_bits;
  assign unused_psr_bits = ^psrWrData[WIDTH-1:5];

  // Next-state: an ALU capture outranks a direct PSR write in the same cycle.
  always_comb begin
    flags_d = flags_q;
    valid_d = valid_q;
    if (codesComputed) begin
      flags_d = aluFlags;
      valid_d = 1'b1;
    end else if (psrWrEn) begin
      flags_d = psrWrData[4:0];
      valid_d = 1'b1;
    end
  end

  // Flag register with asynchronous clear; a capture pending during reset is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 5'b0;
      valid_q <= 1'b0;
    end else begin
      flags_q <= flags_d;
      valid_q <= valid_d;
    end
  end

  // Effective flags: optionally forward the ALU flags during the capture cycle.
  always_comb begin
    eff_flags = flags_q;
    if (BYPASS && codesComputed) begin
      eff_flags = aluFlags;
    end
  end

  // Condition mux; unknown condField resolves to "not met" via the default.
  always_comb begin
    cond_met = 1'b0;
    case (condField)
      4'b0000: cond_met =  eff_flags[Z_BIT];
      4'b0001: cond_met = ~eff_flags[Z_BIT];
      4'b0010: cond_met =  eff_flags[C_BIT];
      4'b0011: cond_met = ~eff_flags[C_BIT];
      4'b0100: cond_met =  eff_flags[L_BIT];
      4'b0101: cond_met = ~eff_flags[L_BIT];
      4'b0110: cond_met =  eff_flags[N_BIT];
      4'b0111: cond_met = ~eff_flags[N_BIT];
      4'b1000: cond_met =  eff_flags[F_BIT];
      4'b1001: cond_met = ~eff_flags[F_BIT];
      4'b1010: cond_met = ~eff_flags[L_BIT] & ~eff_flags[Z_BIT];
      4'b1011: cond_met =  eff_flags[L_BIT] |  eff_flags[Z_BIT];
      4'b1100: cond_met = ~eff_flags[N_BIT] & ~eff_flags[Z_BIT];
      4'b1101: cond_met =  eff_flags[N_BIT] |  eff_flags[Z_BIT];
      4'b1110: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  // Outputs: the flag field and carry always show stored state, never the bypass.
  always_comb begin
    conCodesOut      = '0;
    conCodesOut[5:1] = flags_q;
    conCodesOut[0]   = cond_met;
    sCondValue       = '0;
    sCondValue[0]    = cond_met;
    carryIn          = flags_q[C_BIT];
    flagsValid       = valid_q;
  end

endmodule

// File: tb/tb_cond_code_unit.sv
// Bench for cond_code_unit: a BYPASS=0 and a BYPASS=1 instance share every input.
// Directed reset/capture/priority/sweep/bypass/async-reset steps plus a randomized phase.
// Expected values come from a flag-level model and a predicate-pair condition table.
module tb_cond_code_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        codesComputed;
  logic [4:0]  aluFlags;
  logic        psrWrEn;
  logic [15:0] psrWrData;
  logic [3:0]  condField;

  logic [15:0] cco0, cco1, scv0, scv1;
  logic        carry0, carry1, valid0, valid1;

  int checks = 0;
  int errors = 0;

  // Reference state: stored flags {N,Z,F,L,C} and the valid bit.
  logic [4:0] m_flags;
  logic       m_valid;

  always #5 clk = ~clk;

  cond_code_unit #(.WIDTH(16), .BYPASS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .codesComputed(codesComputed), .aluFlags(aluFlags),
    .psrWrEn(psrWrEn), .psrWrData(psrWrData), .condField(condField),
    .conCodesOut(cco0), .carryIn(carry0), .sCondValue(scv0), .flagsValid(valid0)
  );

  cond_code_unit #(.WIDTH(16), .BYPASS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .codesComputed(codesComputed), .aluFlags(aluFlags),
    .psrWrEn(psrWrEn), .psrWrData(psrWrData), .condField(condField),
    .conCodesOut(cco1), .carryIn(carry1), .sCondValue(scv1), .flagsValid(valid1)
  );

  // Even codes are a base predicate; each odd code is the complement of its even partner.
  function automatic logic cond_ref(input logic [3:0] code, input logic [4:0] f);
    logic n, z, fl, l, c, base;
    n = f[4]; z = f[3]; fl = f[2]; l = f[1]; c = f[0];
    base = 1'b0;
    case (code[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = l;
      3'd3: base = n;
      3'd4: base = fl;
      3'd5: base = !l && !z;
      3'd6: base = !n && !z;
      default: base = 1'b1;
    endcase
    return base ^ code[0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output of both instances against the model for the current inputs.
  task automatic check_all(input string tag);
    logic [4:0]  eff1;
    logic [15:0] e0, e1;
    eff1 = codesComputed ? aluFlags : m_flags;
    e0 = {10'b0, m_flags, cond_ref(condField, m_flags)};
    e1 = {10'b0, m_flags, cond_ref(condField, eff1)};
    check({tag, ".cco0"},   32'(cco0),   32'(e0));
    check({tag, ".cco1"},   32'(cco1),   32'(e1));
    check({tag, ".scv0"},   32'(scv0),   32'({15'b0, e0[0]}));
    check({tag, ".scv1"},   32'(scv1),   32'({15'b0, e1[0]}));
    check({tag, ".carry0"}, 32'(carry0), 32'(m_flags[0]));
    check({tag, ".carry1"}, 32'(carry1), 32'(m_flags[0]));
    check({tag, ".valid0"}, 32'(valid0), 32'(m_valid));
    check({tag, ".valid1"}, 32'(valid1), 32'(m_valid));
  endtask

  // Advance one rising edge, applying the register rule to the model.
  task automatic tick();
    if (reset) begin
      if (codesComputed) begin
        m_flags = aluFlags; m_valid = 1'b1;
      end else if (psrWrEn) begin
        m_flags = psrWrData[4:0]; m_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; codesComputed = 1'b0; aluFlags = '0; psrWrEn = 1'b0;
    psrWrData = '0; condField = '0;
    m_flags = '0; m_valid = 1'b0;

    // Reset held with inputs toggling: nothing may be captured.
    for (int i = 0; i < 4; i++) begin
      codesComputed = 1'($urandom); psrWrEn = 1'($urandom);
      aluFlags = 5'($urandom); psrWrData = 16'($urandom); condField = 4'($urandom);
      tick();
      check("rst_flags", 32'(cco0[5:1]), 32'd0);
      check("rst_carry", 32'(carry0), 32'd0);
      check("rst_valid", 32'(valid0), 32'd0);
    end
    codesComputed = 1'b0; psrWrEn = 1'b0;
    condField = 4'b1110; #1;
    check("rst_uc", 32'(cco0[0]), 32'd1);
    condField = 4'b0000; #1;
    check("rst_eq", 32'(cco0[0]), 32'd0);
    check_all("rst");

    @(negedge clk); reset = 1'b1;
    tick();

    // Capture Z and evaluate EQ / NE.
    codesComputed = 1'b1; aluFlags = 5'b01000; condField = 4'b0000;
    tick();
    codesComputed = 1'b0; #1;
    check("cap_eq", 32'(cco0), 32'h0011);
    condField = 4'b0001; #1;
    check("cap_ne", 32'(cco0), 32'h0010);
    check_all("cap");

    // Capture beats PSR write in the same cycle.
    codesComputed = 1'b1; aluFlags = 5'b00001; psrWrEn = 1'b1; psrWrData = 16'h0010;
    tick();
    codesComputed = 1'b0; #1;
    check("pri_flags", 32'(cco0[5:1]), 32'h01);
    check("pri_carry", 32'(carry0), 32'd1);
    tick();
    psrWrEn = 1'b0; #1;
    check("wr_flags", 32'(cco0[5:1]), 32'h10);
    check("wr_carry", 32'(carry0), 32'd0);
    check_all("pri");

    // Exhaustive: every flag pattern against every condition code.
    for (int p = 0; p < 32; p++) begin
      psrWrEn = 1'b1; psrWrData = {11'($urandom), 5'(p)};
      tick();
      psrWrEn = 1'b0;
      for (int c = 0; c < 16; c++) begin
        condField = 4'(c); #1;
        check_all("sweep");
      end
    end

    // Bypass: Z=0 stored, ALU reports Z=1 during the capture cycle.
    psrWrEn = 1'b1; psrWrData = 16'h0000;
    tick();
    psrWrEn = 1'b0; codesComputed = 1'b1; aluFlags = 5'b01000; condField = 4'b0000; #1;
    check("byp_on",    32'(cco1[0]), 32'd1);
    check("byp_off",   32'(cco0[0]), 32'd0);
    check("byp_field", 32'(cco1[5:1]), 32'd0);
    check_all("byp");
    tick();
    codesComputed = 1'b0; #1;
    check("byp_edge0", 32'(cco0[0]), 32'd1);
    check_all("byp_after");

    // Randomized traffic, checked combinationally before each edge.
    for (int i = 0; i < 200; i++) begin
      codesComputed = ($urandom_range(0, 3) == 0);
      psrWrEn       = ($urandom_range(0, 3) == 0);
      aluFlags      = 5'($urandom);
      psrWrData     = 16'($urandom);
      condField     = 4'($urandom);
      #1;
      check_all("rand");
      tick();
    end

    // Asynchronous reset between edges clears flags with no clock.
    codesComputed = 1'b0; psrWrEn = 1'b1; psrWrData = 16'h001F;
    tick();
    psrWrEn = 1'b0; #1;
    check("ar_pre", 32'(cco0[5:1]), 32'h1F);
    @(negedge clk); #2;
    reset = 1'b0; m_flags = '0; m_valid = 1'b0; #1;
    check("ar_flags", 32'(cco0[5:1]), 32'd0);
    check("ar_carry", 32'(carry1), 32'd0);
    check("ar_valid", 32'(valid0), 32'd0);
    codesComputed = 1'b1; aluFlags = 5'b10101;
    tick();
    check_all("ar_hold");
    codesComputed = 1'b0;
    @(negedge clk); reset = 1'b1; #1;
    check_all("ar_rel");
    codesComputed = 1'b1; aluFlags = 5'($urandom);
    tick();
    codesComputed = 1'b0; #1;
    check("ar_first_valid", 32'(valid0), 32'd1);
    check_all("ar_first");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
